cache_fill_ctrl: RTL and testbench

Miss-handling controller that sequences refills of the 64-block × 8-word cache data array. On a miss it captures the block address and issues one read request per word to the 4-cycle-latency main memory. It steers each returning word into the data array through a one-hot word enable, then pulses the tag-array write to validate the block. It sits between the cache hit/miss logic, main memory and the data/tag arrays, and holds the pipeline via `fsm_busy`.

---
 rtl/cache_fill_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Refill sequencer for the 64-block x 8-word cache: requests a missing block word-by-word
// and steers returns into the data array. Define CACHE_FILL_CWF_EN for critical-word-first order.

module cache_fill_dff #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain resettable register cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

module cache_fill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_req,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [7:0]  word_enable,
  output logic        write_tag_array,
  output logic        fill_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  state_q;
  logic [15:0] base;
  logic [3:0]  req_cnt;
  logic [3:0]  rsp_cnt;
  logic [2:0]  req_idx;
  logic [2:0]  rsp_idx;

  cache_fill_dff #(
    .W       (2),
    .RST_VAL (2'd0)
  ) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_next),
    .q   (state_q)
  );

  assign state = state_t'(state_q);

`ifdef CACHE_FILL_CWF_EN
  logic [2:0] offset;

  // Start word of the fill; both request and response order rotate from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= 3'd0;
    end else if (state == IDLE && miss_detected) begin
      offset <= miss_address[3:1];
    end else begin
      offset <= offset;
    end
  end

  assign req_idx = offset + req_cnt[2:0];
  assign rsp_idx = offset + rsp_cnt[2:0];
`else
  assign req_idx = req_cnt[2:0];
  assign rsp_idx = rsp_cnt[2:0];
`endif

  // Next-state decode plus all handshake outputs; writes follow memory_data_valid directly.
  always_comb begin
    state_next       = state;
    mem_req          = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    word_enable      = 8'h00;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    fsm_busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        mem_req = (req_cnt < 4'd8);
        if (mem_req) begin
          // base has a zero low nibble, so the offset can never carry upward.
          memory_address = base + {12'h000, req_idx, 1'b0};
        end else begin
          memory_address = 16'h0000;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_enable      = 8'h01 << rsp_idx;
          if (rsp_cnt == 4'd7) begin
            state_next = TAG;
          end else begin
            state_next = FILL;
          end
        end else begin
          state_next = FILL;
        end
      end
      TAG: begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Block base and request/response counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base    <= 16'h0000;
      req_cnt <= 4'd0;
      rsp_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address & 16'hFFF0;
            req_cnt <= 4'd0;
            rsp_cnt <= 4'd0;
          end else begin
            base    <= base;
            req_cnt <= req_cnt;
            rsp_cnt <= rsp_cnt;
          end
        end
        FILL: begin
          base <= base;
          if (mem_req) begin
            req_cnt <= req_cnt + 4'd1;
          end else begin
            req_cnt <= req_cnt;
          end
          if (write_data_array) begin
            rsp_cnt <= rsp_cnt + 4'd1;
          end else begin
            rsp_cnt <= rsp_cnt;
          end
        end
        default: begin
          base    <= base;
          req_cnt <= req_cnt;
          rsp_cnt <= rsp_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: a 4-cycle memory answers the DUT's requests and a
// per-fill timeline model (relative cycle -> expected outputs) predicts every output each cycle.

module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic        write_tag_array;
  logic        fill_done;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          miss_cyc = -1000;
  int          free_at  = 0;
  logic [15:0] m_base = 16'h0000;
  logic [2:0]  m_off  = 3'd0;
  bit          req_hist [0:2047];

  cache_fill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_enable       (word_enable),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] idx(int k);
`ifdef CACHE_FILL_CWF_EN
    return 3'((int'(m_off) + k) % 8);
`else
    return 3'(k % 8);
`endif
  endfunction

  // Expected outputs for absolute cycle t from the position inside the current fill.
  function automatic logic [28:0] exp_vec(int t);
    int r;
    logic busy, req, we, tag;
    logic [15:0] addr;
    logic [7:0] wen;
    r = t - miss_cyc;
    busy = 1'b0; req = 1'b0; we = 1'b0; tag = 1'b0; addr = 16'h0000; wen = 8'h00;
    if (r >= 1 && r <= 13) busy = 1'b1;
    if (r >= 1 && r <= 8) begin
      req  = 1'b1;
      addr = m_base + 16'(2 * int'(idx(r - 1)));
    end
    if (r >= 5 && r <= 12) begin
      we  = 1'b1;
      wen = 8'h01 << idx(r - 5);
    end
    if (r == 13) tag = 1'b1;
    return {busy, req, addr, we, wen, tag, tag};
  endfunction

  function automatic logic [28:0] obs_vec();
    return {fsm_busy, mem_req, memory_address, write_data_array, word_enable,
            write_tag_array, fill_done};
  endfunction

  function automatic bit in_fill(int t);
    return (t - miss_cyc >= 1) && (t - miss_cyc <= 12);
  endfunction

  // One clock: drive inputs after the edge, update the model, sample at the falling edge.
  task automatic tick(input logic m, input logic [15:0] a, input logic stray);
    @(posedge clk);
    cyc++;
    #1;
    miss_detected     = m;
    miss_address      = a;
    memory_data_valid = (cyc >= 4 && req_hist[cyc - 4]) | stray;
    if (m && cyc >= free_at) begin
      miss_cyc = cyc;
      m_base   = a & 16'hFFF0;
      m_off    = a[3:1];
      free_at  = cyc + 14;
    end
    @(negedge clk);
    req_hist[cyc] = mem_req;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs_vec() !== 29'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 29'h0);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_fill_order(input logic [15:0] a);
    tick(1'b1, a, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        fails++;
        $display("FAIL fill_%h r=%0d got=%h exp=%h", a, i, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_miss_during_fill();
    tick(1'b1, 16'h1236, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick(i == 3, (i == 3) ? 16'h4000 : 16'h0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec(cyc) || (mem_req && memory_address[15:4] !== 12'h123)) begin
        fails++;
        $display("FAIL miss_in_fill r=%0d got=%h exp=%h", i, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_stray_valid();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0000, 1'b1);
      checks++;
      if (write_data_array !== 1'b0 || word_enable !== 8'h00 || fsm_busy !== 1'b0) begin
        fails++;
        $display("FAIL stray_idle got we=%b wen=%h busy=%b exp 0 00 0",
                 write_data_array, word_enable, fsm_busy);
      end
    end
    // A following fill must start at response index 0 with a complete 8-word sequence.
    tick(1'b1, 16'h0A0C, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 16'h0000, (i == 13));
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        fails++;
        $display("FAIL stray_then_fill r=%0d got=%h exp=%h", i, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    tick(1'b1, 16'h1236, 1'b0);
    for (int i = 1; i <= 6; i++) tick(1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
    miss_detected     = 1'b0;
    memory_data_valid = req_hist[cyc - 4];
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 29'h0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), 29'h0);
    end
    req_hist[cyc] = 1'b0;
    miss_cyc = -1000;
    free_at  = 0;
    tick(1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (obs_vec() !== 29'h0) begin
        fails++;
        $display("FAIL post_reset_idle i=%0d got=%h exp=%h", i, obs_vec(), 29'h0);
      end
    end
    tick(1'b1, 16'hFFFE, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec(cyc) || (mem_req && memory_address[15:4] !== 12'hFFF)) begin
        fails++;
        $display("FAIL fill_fffe r=%0d got=%h exp=%h", i, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    tick(1'b1, 16'h2468, 1'b0);
    first = cyc;
    for (int i = 1; i <= 30; i++) begin
      tick(i < 20, 16'h5552, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        fails++;
        $display("FAIL back_to_back r=%0d got=%h exp=%h", i, obs_vec(), exp_vec(cyc));
      end
    end
    checks++;
    if (miss_cyc !== first + 14) begin
      fails++;
      $display("FAIL b2b_restart got=%0d exp=%0d", miss_cyc - first, 14);
    end
  endtask

  task automatic test_random();
    logic        m;
    logic [15:0] a;
    logic        s;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 5) == 0);
      a = 16'($urandom);
      s = ($urandom_range(0, 2) == 0) && !in_fill(cyc + 1);
      tick(m, a, s);
      checks++;
      if (obs_vec() !== exp_vec(cyc)) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec(cyc));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_order(16'h1236);
    test_miss_during_fill();
    test_stray_valid();
    test_reset_mid_fill();
    test_back_to_back();
    test_fill_order(16'h7FFE);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
